// File: rtl/team_06_pkg.sv
// team_06 shared types and constants for the audio path.
// Used by team_06_i2s_rx and its neighbours.
package team_06_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;

    typedef logic signed [7:0] sample8_t;

    typedef enum logic {
        RX_IDLE,
        RX_RUN
    } i2s_rx_state_t;

endpackage

// File: rtl/team_06_sync2.sv
// team_06_sync2: generic two-flop synchroniser, async active-low reset.
// Reusable for adc data, miso and push buttons.
module team_06_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // two register stages to settle metastability on asynchronous inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/team_06_i2s_rx.sv
// team_06_i2s_rx: mono I2S receiver, left slot reduced to OUT_BITS.
// Optional rounding/saturation with TEAM_06_I2S_RX_ROUND_EN.
module team_06_i2s_rx
    import team_06_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int SLOT_BITS   = I2S_SLOT_BITS,
    parameter int OUT_BITS    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       i2sclk,
    input  logic                       past_i2sclk,
    input  logic                       adc_serial_in,
    output logic                       ws,
    output logic signed [OUT_BITS-1:0] i2s_parallel_out,
    output logic                       finished
);

    localparam int CNT_W = $clog2(2 * SLOT_BITS);

    localparam logic [CNT_W-1:0] SLOT_C = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] SAMP_C = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    i2s_rx_state_t          state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [SAMPLE_BITS-1:0] shift;
    logic                   load;
    logic                   sd;
    logic                   rise;
    logic                   fall;
    logic                   in_window;

    team_06_sync2 #(
        .WIDTH(1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (adc_serial_in),
        .q   (sd)
    );

    assign rise      = i2sclk & ~past_i2sclk;
    assign fall      = ~i2sclk & past_i2sclk;
    assign cnt_next  = bit_cnt + ONE_C;
    assign in_window = (bit_cnt >= ONE_C) && (bit_cnt <= SAMP_C);

    function automatic logic [OUT_BITS-1:0] reduce(
        input logic [SAMPLE_BITS-1:0] s
    );
`ifdef TEAM_06_I2S_RX_ROUND_EN
        logic [OUT_BITS-1:0] top;
        logic                rnd;
        logic [OUT_BITS:0]   sum;
        top = s[SAMPLE_BITS-1 -: OUT_BITS];
        rnd = s[SAMPLE_BITS-OUT_BITS-1];
        sum = {top[OUT_BITS-1], top} + {{OUT_BITS{1'b0}}, rnd};
        // adding a non-negative bit can only overflow upwards
        if (sum[OUT_BITS] != sum[OUT_BITS-1]) begin
            return {1'b0, {(OUT_BITS-1){1'b1}}};
        end
        return sum[OUT_BITS-1:0];
`else
        return s[SAMPLE_BITS-1 -: OUT_BITS];
`endif
    endfunction

    // receiver FSM: frame counting, ws, capture and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= RX_IDLE;
            bit_cnt          <= '0;
            ws               <= 1'b0;
            shift            <= '0;
            load             <= 1'b0;
            i2s_parallel_out <= '0;
            finished         <= 1'b0;
        end else begin
            finished <= 1'b0;
            load     <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    ws      <= 1'b0;
                    shift   <= '0;
                    if (en) begin
                        state <= RX_RUN;
                    end
                end
                RX_RUN: begin
                    if (!en) begin
                        state   <= RX_IDLE;
                        bit_cnt <= '0;
                        ws      <= 1'b0;
                        shift   <= '0;
                    end else begin
                        if (fall) begin
                            bit_cnt <= cnt_next;
                            ws      <= (cnt_next >= SLOT_C);
                        end
                        if (rise && in_window) begin
                            shift <= {shift[SAMPLE_BITS-2:0], sd};
                            load  <= (bit_cnt == SAMP_C);
                        end
                        if (load) begin
                            i2s_parallel_out <= reduce(shift);
                            finished         <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
